// File: rtl/exe_stage.sv
// Execute stage: drives the external combinational ALU, runs multi-cycle muls,
// and holds one registered result for the memory stage behind a valid/ready handshake.
module exe_stage #(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [7:0]  dec_instr,
  input  logic [31:0] dec_val1,
  input  logic [31:0] dec_val2,
  input  logic [31:0] dec_sdata,
  input  logic [4:0]  dec_rd,
  output logic [7:0]  alu_instr,
  output logic [31:0] alu_val1,
  output logic [31:0] alu_val2,
  input  logic [31:0] alu_out,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [7:0]  mem_instr,
  output logic [31:0] mem_result,
  output logic [31:0] mem_sdata,
  output logic [4:0]  mem_rd,
  output logic        mem_wb_en,
  output logic        br_taken,
  output logic        illegal
);
  localparam logic [7:0]    OP_MUL   = 8'h02;
  localparam int unsigned   CW       = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LATENCY - 1);

  typedef enum logic {ST_IDLE, ST_MUL_WAIT} state_t;

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [7:0]    r_op_instr, w_op_instr_n;
  logic [31:0]   r_op_val1, w_op_val1_n;
  logic [31:0]   r_op_val2, w_op_val2_n;
  logic [31:0]   r_op_sdata, w_op_sdata_n;
  logic [4:0]    r_op_rd, w_op_rd_n;
  logic          r_mem_valid, w_mem_valid_n;
  logic [7:0]    r_mem_instr, w_mem_instr_n;
  logic [31:0]   r_mem_result, w_mem_result_n;
  logic [31:0]   r_mem_sdata, w_mem_sdata_n;
  logic [4:0]    r_mem_rd, w_mem_rd_n;
  logic          r_mem_wb_en, w_mem_wb_en_n;
  logic          r_br_taken, w_br_taken_n;
  logic          r_illegal, w_illegal_n;

  logic          w_idle, w_out_free, w_accept, w_load;
  logic [31:0]   w_src_sdata;
  logic [4:0]    w_src_rd;
  logic [31:0]   w_dec_result;
  logic          w_dec_wb, w_dec_br, w_dec_ill;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_out_free = !r_mem_valid || mem_ready;
  assign dec_ready  = !flush && w_idle && w_out_free;
  assign w_accept   = dec_valid && dec_ready;

  // The ALU sees decode directly when idle, the latched mul operands while waiting.
  assign alu_instr   = w_idle ? dec_instr : r_op_instr;
  assign alu_val1    = w_idle ? dec_val1  : r_op_val1;
  assign alu_val2    = w_idle ? dec_val2  : r_op_val2;
  assign w_src_sdata = w_idle ? dec_sdata : r_op_sdata;
  assign w_src_rd    = w_idle ? dec_rd    : r_op_rd;

  always_comb begin
    w_dec_result = '0;
    w_dec_wb     = 1'b0;
    w_dec_br     = 1'b0;
    w_dec_ill    = 1'b0;
    case (alu_instr)
      8'h00, 8'h01, 8'h02, 8'h10, 8'h11: begin
        w_dec_result = alu_out;
        w_dec_wb     = 1'b1;
      end
      8'h12, 8'h13: w_dec_result = alu_out;
      8'h30: begin
        w_dec_result = alu_out;
        w_dec_br     = alu_out[0];
      end
      8'h31: begin
        w_dec_result = alu_out;
        w_dec_br     = 1'b1;
      end
      8'h32, 8'h33: begin
      end
      default: w_dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_op_instr_n   = r_op_instr;
    w_op_val1_n    = r_op_val1;
    w_op_val2_n    = r_op_val2;
    w_op_sdata_n   = r_op_sdata;
    w_op_rd_n      = r_op_rd;
    w_mem_valid_n  = r_mem_valid && !mem_ready;
    w_mem_instr_n  = r_mem_instr;
    w_mem_result_n = r_mem_result;
    w_mem_sdata_n  = r_mem_sdata;
    w_mem_rd_n     = r_mem_rd;
    w_mem_wb_en_n  = r_mem_wb_en;
    w_br_taken_n   = r_br_taken;
    w_illegal_n    = r_illegal;
    w_load         = 1'b0;

    if (flush) begin
      w_state_n     = ST_IDLE;
      w_cnt_n       = '0;
      w_mem_valid_n = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (dec_instr == OP_MUL) begin
              w_state_n    = ST_MUL_WAIT;
              w_cnt_n      = CNT_INIT;
              w_op_instr_n = dec_instr;
              w_op_val1_n  = dec_val1;
              w_op_val2_n  = dec_val2;
              w_op_sdata_n = dec_sdata;
              w_op_rd_n    = dec_rd;
            end else begin
              w_load = 1'b1;
            end
          end
        end
        ST_MUL_WAIT: begin
          if (r_cnt > CW'(1)) begin
            w_cnt_n = r_cnt - CW'(1);
          end else if (w_out_free) begin
            w_load    = 1'b1;
            w_state_n = ST_IDLE;
            w_cnt_n   = '0;
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
    end

    if (w_load) begin
      w_mem_valid_n  = 1'b1;
      w_mem_instr_n  = alu_instr;
      w_mem_result_n = w_dec_result;
      w_mem_sdata_n  = w_src_sdata;
      w_mem_rd_n     = w_src_rd;
      w_mem_wb_en_n  = w_dec_wb;
      w_br_taken_n   = w_dec_br;
      w_illegal_n    = w_dec_ill;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_op_instr   <= '0;
      r_op_val1    <= '0;
      r_op_val2    <= '0;
      r_op_sdata   <= '0;
      r_op_rd      <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_instr  <= '0;
      r_mem_result <= '0;
      r_mem_sdata  <= '0;
      r_mem_rd     <= '0;
      r_mem_wb_en  <= 1'b0;
      r_br_taken   <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_op_instr   <= w_op_instr_n;
      r_op_val1    <= w_op_val1_n;
      r_op_val2    <= w_op_val2_n;
      r_op_sdata   <= w_op_sdata_n;
      r_op_rd      <= w_op_rd_n;
      r_mem_valid  <= w_mem_valid_n;
      r_mem_instr  <= w_mem_instr_n;
      r_mem_result <= w_mem_result_n;
      r_mem_sdata  <= w_mem_sdata_n;
      r_mem_rd     <= w_mem_rd_n;
      r_mem_wb_en  <= w_mem_wb_en_n;
      r_br_taken   <= w_br_taken_n;
      r_illegal    <= w_illegal_n;
    end
  end

  assign mem_valid  = r_mem_valid;
  assign mem_instr  = r_mem_instr;
  assign mem_result = r_mem_result;
  assign mem_sdata  = r_mem_sdata;
  assign mem_rd     = r_mem_rd;
  assign mem_wb_en  = r_mem_wb_en;
  assign br_taken   = r_br_taken;
  assign illegal    = r_illegal;
endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed vector table, hand-written handshake/flush/reset
// sequences, and random traffic against a transaction-level reference model.
module tb_exe_stage;
  localparam int unsigned L = 3;

  logic        clock = 1'b0;
  logic        reset, flush, dec_valid, dec_ready;
  logic [7:0]  dec_instr;
  logic [31:0] dec_val1, dec_val2, dec_sdata;
  logic [4:0]  dec_rd;
  logic [7:0]  alu_instr;
  logic [31:0] alu_val1, alu_val2, alu_out;
  logic        mem_valid, mem_ready;
  logic [7:0]  mem_instr;
  logic [31:0] mem_result, mem_sdata;
  logic [4:0]  mem_rd;
  logic        mem_wb_en, br_taken, illegal;

  exe_stage #(.MUL_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_val1(dec_val1), .dec_val2(dec_val2),
    .dec_sdata(dec_sdata), .dec_rd(dec_rd),
    .alu_instr(alu_instr), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_out(alu_out),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_instr(mem_instr), .mem_result(mem_result), .mem_sdata(mem_sdata),
    .mem_rd(mem_rd), .mem_wb_en(mem_wb_en), .br_taken(br_taken), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  rd;
  } in_t;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a, b, sd;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        wb, br, ill;
    int          lat;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Environment ALU: branch compare for beq, subtract/multiply, otherwise an adder.
  function automatic logic [31:0] alu_f(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      8'h01:   return a - b;
      8'h02:   return a * b;
      8'h30:   return {31'b0, a == b};
      default: return a + b;
    endcase
  endfunction

  always_comb alu_out = alu_f(alu_instr, alu_val1, alu_val2);

  // Expected memory-stage payload {instr, result, sdata, rd, wb_en, br_taken, illegal}.
  function automatic logic [79:0] expect_out(input in_t x);
    logic [31:0] r, res;
    logic wb, br, ill;
    r = alu_f(x.op, x.a, x.b);
    res = 32'd0; wb = 1'b0; br = 1'b0; ill = 1'b0;
    case (x.op)
      8'h00, 8'h01, 8'h02, 8'h10, 8'h11: begin res = r; wb = 1'b1; end
      8'h12, 8'h13: res = r;
      8'h30: begin res = r; br = r[0]; end
      8'h31: begin res = r; br = 1'b1; end
      8'h32, 8'h33: res = 32'd0;
      default: ill = 1'b1;
    endcase
    return {x.op, res, x.sd, x.rd, wb, br, ill};
  endfunction

  function automatic logic [79:0] dut_payload();
    return {mem_instr, mem_result, mem_sdata, mem_rd, mem_wb_en, br_taken, illegal};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input in_t x);
    dec_instr = x.op; dec_val1 = x.a; dec_val2 = x.b; dec_sdata = x.sd; dec_rd = x.rd;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; flush = 1'b0; dec_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic in_t rand_instr();
    logic [7:0] ops [11] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13,
                             8'h30, 8'h31, 8'h32, 8'h33};
    int unsigned idx;
    in_t x;
    idx  = $urandom_range(0, 12);
    x.op = (idx < 11) ? ops[idx] : 8'($urandom);
    x.a  = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
    x.b  = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
    x.sd = $urandom;
    x.rd = 5'($urandom);
    return x;
  endfunction

  vec_t vecs [16];
  in_t  cur;
  int   lat;
  // Reference-model state: one output slot, plus a pending mul with cycles left.
  logic        m_ov;
  logic [79:0] m_out;
  int          m_rem;
  in_t         m_pend;
  logic        exp_ready, free;

  initial begin
    vecs[0]  = '{8'h00, 32'd5,         32'd7, 32'd0,         5'd3,  32'd12,         1, 0, 0, 1};
    vecs[1]  = '{8'h01, 32'd0,         32'd1, 32'd0,         5'd4,  32'hFFFFFFFF,   1, 0, 0, 1};
    vecs[2]  = '{8'h02, 32'd6,         32'd7, 32'd11,        5'd5,  32'd42,         1, 0, 0, L};
    vecs[3]  = '{8'h02, 32'hFFFFFFFF,  32'd2, 32'd0,         5'd6,  32'hFFFFFFFE,   1, 0, 0, L};
    vecs[4]  = '{8'h00, 32'hFFFFFFFF,  32'd1, 32'd0,         5'd7,  32'd0,          1, 0, 0, 1};
    vecs[5]  = '{8'h10, 32'h100,       32'd3, 32'd0,         5'd8,  32'h103,        1, 0, 0, 1};
    vecs[6]  = '{8'h11, 32'h1000,      32'd4, 32'd0,         5'd9,  32'h1004,       1, 0, 0, 1};
    vecs[7]  = '{8'h12, 32'h200,       32'd1, 32'hAB,        5'd0,  32'h201,        0, 0, 0, 1};
    vecs[8]  = '{8'h13, 32'h2000,      32'd8, 32'hDEADBEEF,  5'd1,  32'h2008,       0, 0, 0, 1};
    vecs[9]  = '{8'h30, 32'd9,         32'd9, 32'd0,         5'd2,  32'd1,          0, 1, 0, 1};
    vecs[10] = '{8'h30, 32'd9,         32'd8, 32'd0,         5'd2,  32'd0,          0, 0, 0, 1};
    vecs[11] = '{8'h31, 32'h40,        32'd4, 32'd0,         5'd10, 32'h44,         0, 1, 0, 1};
    vecs[12] = '{8'h32, 32'd3,         32'd4, 32'd0,         5'd11, 32'd0,          0, 0, 0, 1};
    vecs[13] = '{8'h33, 32'd1,         32'd1, 32'd0,         5'd12, 32'd0,          0, 0, 0, 1};
    vecs[14] = '{8'hFF, 32'd5,         32'd6, 32'd0,         5'd13, 32'd0,          0, 0, 1, 1};
    vecs[15] = '{8'h20, 32'd1,         32'd2, 32'd0,         5'd14, 32'd0,          0, 0, 1, 1};

    reset = 1'b1; flush = 1'b0; dec_valid = 1'b0; mem_ready = 1'b1;
    drive('0);

    // Directed vectors: each from a fresh reset, single instruction, unstalled.
    for (int i = 0; i < 16; i++) begin
      do_reset();
      #1;
      check("reset_state", {mem_valid, dut_payload()}, 81'd0);
      check("reset_ready", dec_ready, 1'b1);
      drive('{vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sd, vecs[i].rd});
      dec_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      dec_valid = 1'b0;
      lat = 1;
      while (!mem_valid && lat < 20) begin
        @(negedge clock);
        lat++;
      end
      #1;
      check("vec_payload", dut_payload(),
            {vecs[i].op, vecs[i].res, vecs[i].sd, vecs[i].rd, vecs[i].wb, vecs[i].br, vecs[i].ill});
      check("vec_latency", lat, vecs[i].lat);
    end

    // mul 6*7: decode blocked while waiting, next instruction taken as result appears.
    do_reset();
    drive('{8'h02, 32'd6, 32'd7, 32'd0, 5'd5});
    dec_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    drive('{8'h00, 32'd1, 32'd2, 32'd0, 5'd6});
    for (int i = 1; i < L; i++) begin
      #1;
      check("mul_wait_ready", dec_ready, 1'b0);
      check("mul_wait_valid", mem_valid, 1'b0);
      @(negedge clock);
    end
    #1;
    check("mul_done", {mem_valid, mem_result, mem_rd}, {1'b1, 32'd42, 5'd5});
    check("mul_next_ready", dec_ready, 1'b1);
    @(negedge clock);
    dec_valid = 1'b0;
    #1;
    check("mul_follow", {mem_valid, mem_result, mem_rd}, {1'b1, 32'd3, 5'd6});

    // Downstream stall: result held, decode blocked, back-to-back release.
    do_reset();
    mem_ready = 1'b0;
    drive('{8'h01, 32'd0, 32'd1, 32'd0, 5'd4});
    dec_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    drive('{8'h00, 32'd10, 32'd20, 32'd0, 5'd6});
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_hold", {mem_valid, dut_payload()},
            {1'b1, expect_out('{8'h01, 32'd0, 32'd1, 32'd0, 5'd4})});
      check("stall_ready", dec_ready, 1'b0);
      @(negedge clock);
    end
    mem_ready = 1'b1;
    #1;
    check("stall_release_ready", dec_ready, 1'b1);
    @(negedge clock);
    dec_valid = 1'b0;
    #1;
    check("stall_b2b", {mem_valid, mem_result, mem_rd}, {1'b1, 32'd30, 5'd6});

    // Flush one cycle after mul acceptance.
    do_reset();
    drive('{8'h02, 32'd6, 32'd7, 32'd0, 5'd5});
    dec_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    dec_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_ready_low", dec_ready, 1'b0);
    @(negedge clock);
    flush = 1'b0;
    #1;
    check("flush_ready_after", dec_ready, 1'b1);
    for (int i = 0; i <= L; i++) begin
      check("flush_no_valid", mem_valid, 1'b0);
      @(negedge clock);
      #1;
    end

    // Reset one cycle after mul acceptance, with a non-zero payload left over.
    do_reset();
    drive('{8'h00, 32'd1, 32'd2, 32'h55, 5'd9});
    dec_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    drive('{8'h02, 32'd6, 32'd7, 32'd0, 5'd5});
    @(posedge clock);
    @(negedge clock);
    dec_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_mid_mul_outputs", {mem_valid, dut_payload()}, 81'd0);
    check("rst_mid_mul_ready", dec_ready, 1'b1);
    for (int i = 0; i <= L; i++) begin
      check("rst_no_valid", mem_valid, 1'b0);
      @(negedge clock);
      #1;
    end

    // Eight adds streamed with continuous valid/ready.
    do_reset();
    mem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive('{8'h00, 32'(k), 32'd100, 32'd0, 5'(k)});
      dec_valid = 1'b1;
      #1;
      check("stream_ready", dec_ready, 1'b1);
      if (k > 0) check("stream_out", {mem_valid, mem_result}, {1'b1, 32'(k - 1 + 100)});
      @(negedge clock);
    end
    dec_valid = 1'b0;
    #1;
    check("stream_last", {mem_valid, mem_result}, {1'b1, 32'd107});

    // Random traffic against the reference model.
    do_reset();
    m_ov = 1'b0; m_rem = 0; m_out = '0; m_pend = '0;
    for (int c = 0; c < 1500; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      dec_valid = ($urandom_range(0, 9) < 7);
      mem_ready = ($urandom_range(0, 9) < 7);
      cur       = rand_instr();
      drive(cur);
      #1;
      exp_ready = !flush && (m_rem == 0) && (!m_ov || mem_ready);
      check("rand_ready", dec_ready, exp_ready);
      check("rand_valid", mem_valid, m_ov);
      if (m_ov) check("rand_payload", dut_payload(), m_out);
      if (reset || flush) begin
        m_ov  = 1'b0;
        m_rem = 0;
      end else begin
        free = !m_ov || mem_ready;
        if (m_ov && mem_ready) m_ov = 1'b0;
        if (m_rem > 1) begin
          m_rem--;
        end else if (m_rem == 1) begin
          if (free) begin
            m_out = expect_out(m_pend);
            m_ov  = 1'b1;
            m_rem = 0;
          end
        end else if (dec_valid && exp_ready) begin
          if (cur.op == 8'h02) begin
            m_pend = cur;
            m_rem  = L - 1;
          end else begin
            m_out = expect_out(cur);
            m_ov  = 1'b1;
          end
        end
      end
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Parameter MUL_LATENCY, default 3: cycles from mul acceptance to result valid; SHALL be >= 2.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 flush  in  1  kill in-flight and held work (branch redirect).
REQ-005 dec_valid  in  1  decode offers an instruction.
REQ-006 dec_ready  out  1  stage accepts this cycle.
REQ-007 dec_instr  in  8  opcode; dec_val1, dec_val2  in  32  operands; dec_sdata  in  32  store data; dec_rd  in  5  destination register.
REQ-008 alu_instr  out  8; alu_val1, alu_val2  out  32: drive the combinational ALU.
REQ-009 alu_out  in  32  combinational ALU result.
REQ-010 mem_valid  out  1; mem_ready  in  1: handshake to memory stage.
REQ-011 mem_instr  out  8; mem_result  out  32; mem_sdata  out  32; mem_rd  out  5; mem_wb_en  out  1; br_taken  out  1; illegal  out  1: registered payload, meaningful only while mem_valid=1.

Function
REQ-012 States: IDLE, MUL_WAIT.
REQ-013 Handshake: transfer on dec_valid && dec_ready; transfer on mem_valid && mem_ready; payload SHALL stay stable while mem_valid && !mem_ready.
REQ-014 dec_ready = !flush && state==IDLE && (!mem_valid || mem_ready).
REQ-015 In IDLE, alu_instr/alu_val1/alu_val2 = dec_instr/dec_val1/dec_val2; in MUL_WAIT they come from internal operand registers latched at acceptance.
REQ-016 Non-mul acceptance at edge T: output register loaded from alu_out and decode fields; mem_valid=1 from cycle T+1 (latency 1, throughput 1/cycle under continuous mem_ready).
REQ-017 mul (8'h02) acceptance at edge T: latch opcode, operands, rd; counter = MUL_LATENCY-1; go MUL_WAIT.
REQ-018 MUL_WAIT: counter decrements each cycle while >1; in the cycle counter==1 and (!mem_valid || mem_ready), capture alu_out, set mem_valid, return to IDLE; mem_valid first high at T+MUL_LATENCY when unstalled.
REQ-019 MUL_WAIT with downstream stalled at counter==1: hold counter=1 and operands; no new acceptance.
REQ-020 mem_result: alu_out for add 00, sub 01, mul 02, ldb 10, ldw 11, stb 12, stw 13, beq 30, jump 31; 0 for tlbwrite 32, iret 33, and undefined opcodes.
REQ-021 mem_wb_en=1 for add, sub, mul, ldb, ldw; else 0.
REQ-022 br_taken=1 for jump, or beq with alu_out[0]=1; else 0.
REQ-023 illegal=1 for any opcode not listed in REQ-020; such instructions are accepted and passed with wb_en=0.
REQ-024 mem_sdata = dec_sdata captured at acceptance; mem_rd = dec_rd; mem_instr = dec_instr.
REQ-025 Arithmetic: 32-bit, wrap-around, no overflow flag; mul keeps low 32 bits.
REQ-026 flush: next edge clears mem_valid, forces IDLE, counter=0; no acceptance in a flush cycle; flush overrides a same-cycle mem_ready transfer only in that mem_valid is cleared (the transfer itself counts as completed).
REQ-027 Output register drained (mem_ready=1) and new instruction accepted in the same cycle SHALL produce back-to-back mem_valid with no bubble.

Reset
REQ-028 reset=1 at an edge: state IDLE, counter 0, mem_valid 0, all mem_* payload, br_taken, illegal = 0; operand registers 0.
REQ-029 reset SHALL take priority over flush, dec_valid and mem_ready; reset mid-MUL_WAIT discards the mul with no mem_valid pulse.
REQ-030 Cycle after reset deasserts: dec_ready=1.

Verification
REQ-031 add 5+7, rd=3, mem_ready=1 -> mem_valid next cycle, mem_result=12, mem_wb_en=1, mem_rd=3.
REQ-032 mul 6*7 at T, mem_ready=1 -> dec_ready=0 cycles T+1..T+2, mem_valid at T+3 with result 42; next instruction accepted at T+3.
REQ-033 sub 0-1 with mem_ready=0 for 4 cycles -> mem_result=32'hFFFFFFFF held stable, dec_ready=0 throughout, released on mem_ready=1.
REQ-034 beq 9,9 -> br_taken=1, result 1, wb_en=0; opcode 8'hFF -> illegal=1, result 0, wb_en=0.
REQ-035 mul accepted, flush at T+1 -> no mem_valid pulse, dec_ready=1 at T+2; repeat with reset at T+1 -> all outputs 0.
REQ-036 stream of 8 adds with continuous dec_valid and mem_ready -> 8 consecutive mem_valid cycles, results in order.
